// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution window generator.
// Window layout is row-major, top (oldest) line first.
package conv_pkg;

    localparam int COLOUR_DEPTH  = 8;
    localparam int KERNAL_WIDTH  = 3;
    localparam int KERNAL_HEIGHT = 3;
    localparam int WIN_SIZE      = KERNAL_WIDTH * KERNAL_HEIGHT;

    typedef logic [COLOUR_DEPTH-1:0] pixel_t;
    typedef pixel_t win_t [WIN_SIZE];

    function automatic int win_idx(input int r, input int c);
        return r * KERNAL_WIDTH + c;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image line of delay: combinational read of the old value and
// a registered write of the new value at the same address.
module conv_line_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are never reset; rows above the window are always
    // rewritten before they can reach an emitted window.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to KERNAL_WIDTH x KERNAL_HEIGHT interior windows,
// one window per accepted pixel once the window is fully inside the image.
module conv_window_gen #(
    parameter int KERNAL_WIDTH  = conv_pkg::KERNAL_WIDTH,
    parameter int KERNAL_HEIGHT = conv_pkg::KERNAL_HEIGHT,
    parameter int COLOUR_DEPTH  = conv_pkg::COLOUR_DEPTH,
    parameter int IMG_WIDTH     = 64,
    parameter int IMG_HEIGHT    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COLOUR_DEPTH-1:0] pix_data,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    output logic                    pix_ready,
    output logic [COLOUR_DEPTH-1:0] win_data [KERNAL_WIDTH*KERNAL_HEIGHT],
    output logic                    win_valid,
    output logic                    win_last,
    input  logic                    win_ready
);

    import conv_pkg::*;

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB = KERNAL_HEIGHT - 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_EMIT = CW'(KERNAL_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_EMIT = RW'(KERNAL_HEIGHT - 1);

    typedef logic [COLOUR_DEPTH-1:0] pix_t;

    logic [CW-1:0] col;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] row;
    logic [RW-1:0] cur_row;
    logic          accept;
    logic          emit;
    logic          frame_end;

    pix_t lb_rd   [LB];
    pix_t lb_wr   [LB];
    pix_t new_col [KERNAL_HEIGHT];
    pix_t win_reg [KERNAL_HEIGHT][KERNAL_WIDTH];

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;

    // pix_sof forces (0,0) so a resync takes effect on this very pixel
    assign cur_col   = pix_sof ? '0 : col;
    assign cur_row   = pix_sof ? '0 : row;

    assign emit      = accept
                    && (cur_row >= ROW_EMIT)
                    && (cur_col >= COL_EMIT);
    assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    for (genvar k = 0; k < LB; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_wr[k] = pix_data;
        end else begin : g_chain
            assign lb_wr[k] = lb_rd[k-1];
        end

        conv_line_buf #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (COLOUR_DEPTH),
            .AW    (CW)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (cur_col),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    for (genvar r = 0; r < KERNAL_HEIGHT; r++) begin : g_col
        if (r == KERNAL_HEIGHT - 1) begin : g_bot
            assign new_col[r] = pix_data;
        end else begin : g_old
            assign new_col[r] = lb_rd[KERNAL_HEIGHT-2-r];
        end
    end

    for (genvar r = 0; r < KERNAL_HEIGHT; r++) begin : g_out_r
        for (genvar c = 0; c < KERNAL_WIDTH; c++) begin : g_out_c
            assign win_data[r*KERNAL_WIDTH+c] = win_reg[r][c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int r = 0; r < KERNAL_HEIGHT; r++) begin
                for (int c = 0; c < KERNAL_WIDTH; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
                for (int r = 0; r < KERNAL_HEIGHT; r++) begin
                    for (int c = 0; c < KERNAL_WIDTH - 1; c++) begin
                        win_reg[r][c] <= win_reg[r][c+1];
                    end
                    win_reg[r][KERNAL_WIDTH-1] <= new_col[r];
                end
            end

            if (emit) begin
                win_valid <= 1'b1;
                win_last  <= frame_end;
            end else if (win_ready) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and randomised-handshake bench for conv_window_gen on a
// 5x4 image with a 3x3 kernel; pixel value = frame base + r*5 + c.
module tb_conv_window_gen;

    import conv_pkg::*;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int KW = 3;
    localparam int KH = 3;
    localparam int N  = KW * KH;

    localparam logic [8*N-1:0] FIRST  = 72'h0C_0B_0A_07_06_05_02_01_00;
    localparam logic [8*N-1:0] THIRD  = 72'h0E_0D_0C_09_08_07_04_03_02;
    localparam logic [8*N-1:0] LASTW  = 72'h13_12_11_0E_0D_0C_09_08_07;
    localparam logic [8*N-1:0] FIRST2 = 72'h20_1F_1E_1B_1A_19_16_15_14;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    pixel_t pix_data = '0;
    logic   pix_valid = 1'b0;
    logic   pix_sof = 1'b0;
    logic   pix_ready;
    pixel_t win_data [N];
    logic   win_valid;
    logic   win_last;
    logic   win_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [8*N-1:0] win_flat;
    logic [8*N-1:0] caps [$];
    bit             lasts [$];

    always #5 clk = ~clk;

    conv_window_gen #(
        .KERNAL_WIDTH  (KW),
        .KERNAL_HEIGHT (KH),
        .COLOUR_DEPTH  (8),
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_last  (win_last),
        .win_ready (win_ready)
    );

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < N; i++) win_flat[i*8 +: 8] = win_data[i];
    end

    // Record every window handshake just before the rising edge
    always begin
        @(negedge clk);
        #4;
        if (win_valid === 1'b1 && win_ready === 1'b1) begin
            caps.push_back(win_flat);
            lasts.push_back(win_last);
        end
    end

    // Reference window k (raster order) of a frame starting at base
    function automatic logic [8*N-1:0] exp_win(input int base, input int k);
        logic [8*N-1:0] v;
        int wr;
        int wc;
        v  = '0;
        wr = k / (W - KW + 1);
        wc = k % (W - KW + 1);
        for (int i = 0; i < KH; i++)
            for (int j = 0; j < KW; j++)
                v[win_idx(i, j)*8 +: 8] = 8'((base + (wr + i) * W + wc + j) % 256);
        return v;
    endfunction

    task automatic clear_caps();
        caps.delete();
        lasts.delete();
    endtask

    // Called just after a falling edge; returns just after a falling edge
    task automatic send_pixel(input logic [7:0] d, input logic sof, input bit rnd);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                win_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        while (!acc && n < 200) begin
            if (rnd) win_ready = 1'($urandom_range(0, 1));
            #1;
            acc = pix_ready;
            @(negedge clk);
            n++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixel=%0d pix_ready stuck low, required accept", d);
        end
    endtask

    task automatic drain();
        win_ready = 1'b1;
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        win_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", win_valid);
        end
        checks++;
        if (win_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last got=%b exp=0", win_last);
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", pix_ready);
        end
        checks++;
        if (win_flat !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", win_flat);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_caps();
        for (int p = 0; p < W * H; p++) begin
            send_pixel(8'(p), p == 0, 1'b0);
            if (p == 11) begin
                #1;
                checks++;
                if (win_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid got=%b exp=0", win_valid);
                end
            end
            if (p == 12) begin
                #1;
                checks++;
                if (win_valid !== 1'b1 || win_flat !== FIRST) begin
                    errors++;
                    $display("FAIL first_latency valid=%b got=%h exp=%h", win_valid, win_flat, FIRST);
                end
            end
        end
        drain();
        checks++;
        if (caps.size() != 6) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=6", caps.size());
        end
        for (int k = 0; k < caps.size() && k < 6; k++) begin
            checks++;
            if (caps[k] !== exp_win(0, k) || lasts[k] !== (k == 5)) begin
                errors++;
                $display("FAIL basic_win k=%0d got=%h last=%b exp=%h last=%b",
                         k, caps[k], lasts[k], exp_win(0, k), k == 5);
            end
        end
        if (caps.size() == 6) begin
            checks++;
            if (caps[0] !== FIRST) begin
                errors++;
                $display("FAIL basic_first got=%h exp=%h", caps[0], FIRST);
            end
            checks++;
            if (caps[5] !== LASTW || lasts[5] !== 1'b1) begin
                errors++;
                $display("FAIL basic_last got=%h last=%b exp=%h last=1", caps[5], lasts[5], LASTW);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_caps();
        for (int p = 0; p < 2 * W * H; p++) send_pixel(8'(p), p == 0, 1'b0);
        drain();
        checks++;
        if (caps.size() != 12) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=12", caps.size());
        end
        for (int k = 0; k < caps.size() && k < 12; k++) begin
            checks++;
            if (caps[k] !== exp_win(20 * (k / 6), k % 6) || lasts[k] !== (k % 6 == 5)) begin
                errors++;
                $display("FAIL b2b_win k=%0d got=%h last=%b exp=%h",
                         k, caps[k], lasts[k], exp_win(20 * (k / 6), k % 6));
            end
        end
        if (caps.size() >= 7) begin
            checks++;
            if (caps[6] !== FIRST2) begin
                errors++;
                $display("FAIL b2b_second_first got=%h exp=%h", caps[6], FIRST2);
            end
        end
    endtask

    task automatic test_backpressure();
        bit held_ok;
        bit stall_ok;
        clear_caps();
        held_ok  = 1'b1;
        stall_ok = 1'b1;
        for (int p = 0; p <= 14; p++) send_pixel(8'(p), p == 0, 1'b0);
        win_ready = 1'b0;
        pix_data  = 8'd15;
        pix_valid = 1'b1;
        repeat (5) begin
            #1;
            if (pix_ready !== 1'b0) stall_ok = 1'b0;
            if (win_valid !== 1'b1 || win_flat !== THIRD) held_ok = 1'b0;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL bp_ready got=1 exp=0 during stall");
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL bp_hold got=%h valid=%b exp=%h", win_flat, win_valid, THIRD);
        end
        for (int p = 15; p < W * H; p++) send_pixel(8'(p), 1'b0, 1'b0);
        drain();
        checks++;
        if (caps.size() != 6) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=6", caps.size());
        end
        for (int k = 0; k < caps.size() && k < 6; k++) begin
            checks++;
            if (caps[k] !== exp_win(0, k) || lasts[k] !== (k == 5)) begin
                errors++;
                $display("FAIL bp_win k=%0d got=%h exp=%h", k, caps[k], exp_win(0, k));
            end
        end
    endtask

    task automatic test_resync();
        clear_caps();
        for (int i = 0; i < 7; i++) send_pixel(8'(100 + i), i == 0, 1'b0);
        for (int p = 0; p < W * H; p++) send_pixel(8'(p), p == 0, 1'b0);
        drain();
        checks++;
        if (caps.size() != 6) begin
            errors++;
            $display("FAIL resync_count got=%0d exp=6", caps.size());
        end
        for (int k = 0; k < caps.size() && k < 6; k++) begin
            checks++;
            if (caps[k] !== exp_win(0, k) || lasts[k] !== (k == 5)) begin
                errors++;
                $display("FAIL resync_win k=%0d got=%h exp=%h", k, caps[k], exp_win(0, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p <= 12; p++) send_pixel(8'(p), p == 0, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_valid got=%b exp=0", win_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_caps();
        @(negedge clk);
        for (int p = 0; p < W * H; p++) send_pixel(8'(p), 1'b0, 1'b0);
        drain();
        checks++;
        if (caps.size() != 6) begin
            errors++;
            $display("FAIL rst_count got=%0d exp=6", caps.size());
        end
        for (int k = 0; k < caps.size() && k < 6; k++) begin
            checks++;
            if (caps[k] !== exp_win(0, k) || lasts[k] !== (k == 5)) begin
                errors++;
                $display("FAIL rst_win k=%0d got=%h exp=%h", k, caps[k], exp_win(0, k));
            end
        end
    endtask

    task automatic test_random();
        int bad;
        clear_caps();
        bad = 0;
        for (int f = 0; f < 10; f++)
            for (int p = 0; p < W * H; p++)
                send_pixel(8'(f * 20 + p), f == 0 && p == 0, 1'b1);
        drain();
        checks++;
        if (caps.size() != 60) begin
            errors++;
            $display("FAIL rand_count got=%0d exp=60", caps.size());
        end
        for (int k = 0; k < caps.size() && k < 60; k++) begin
            checks++;
            if (caps[k] !== exp_win(20 * (k / 6), k % 6) || lasts[k] !== (k % 6 == 5)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL rand_win k=%0d got=%h last=%b exp=%h",
                             k, caps[k], lasts[k], exp_win(20 * (k / 6), k % 6));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream neighbour of the convolution processor. Accepts a raster-order pixel stream and buffers KERNAL_HEIGHT-1 image lines.
- Emits each fully-interior KERNAL_WIDTH x KERNAL_HEIGHT neighbourhood as a flattened window, ready to drive the processor's data_mat input directly.
- No edge padding: only windows lying completely inside the image are produced.

Parameters:
- KERNAL_WIDTH, 3, window columns
- KERNAL_HEIGHT, 3, window rows; number of line buffers = KERNAL_HEIGHT-1
- COLOUR_DEPTH, 8, bits per pixel
- IMG_WIDTH, 64, pixels per line (>= KERNAL_WIDTH)
- IMG_HEIGHT, 64, lines per frame (>= KERNAL_HEIGHT)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pix_data  in  COLOUR_DEPTH  input pixel
- pix_valid  in  1  pix_data valid
- pix_sof  in  1  pixel is (row 0, col 0) of a frame; qualified by pix_valid
- pix_ready  out  1  block accepts a pixel this cycle
- win_data  out  COLOUR_DEPTH x KERNAL_WIDTH*KERNAL_HEIGHT  unpacked window; index = r*KERNAL_WIDTH+c, r=0 top (oldest line), c=0 leftmost (oldest column); centre at index 4 for 3x3
- win_valid  out  1  win_data valid
- win_last  out  1  window is the last of the frame; qualified by win_valid
- win_ready  in  1  downstream accepts the window

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low.
- Reset values:
  - win_valid=0, win_last=0, win_data=all 0, col=0, row=0, window registers=0.
  - Line-buffer contents are not reset; stale data is never emitted.
  - Reset asserted mid-frame aborts the frame. The next accepted pixel is treated as (0,0) whether or not pix_sof is set.
- Accept: pixel accepted when pix_valid && pix_ready. pix_ready = !win_valid || win_ready, combinational.
- Position:
  - An accepted pixel with pix_sof=1 is at (0,0); otherwise it takes the current (row,col).
  - After each accept, col increments. At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. The next frame may follow without pix_sof.
  - pix_sof mid-frame resynchronises counters; the partial frame is discarded.
- Line buffers:
  - Each line buffer is IMG_WIDTH deep, addressed by col, read-before-write.
  - On accept at column c: the new window column (top..bottom) is {lb[KH-2][c], ..., lb[0][c], pix_data}.
  - Then lb[0][c] <= pix_data and lb[k][c] <= lb[k-1][c].
- Window registers: on accept, all columns shift left by one (column 0 dropped) and the new column enters at c=KERNAL_WIDTH-1.
- Emit:
  - Applies when the accepted pixel has row >= KERNAL_HEIGHT-1 and col >= KERNAL_WIDTH-1.
  - Next cycle: win_valid=1 and win_data = shifted window.
  - win_last=1 iff the pixel was (IMG_HEIGHT-1, IMG_WIDTH-1).
- Latency: 1 clock from accepting the completing pixel to win_valid.
- Hold: while win_valid && !win_ready, win_data and win_last are held stable and pix_ready=0.
- Clear: on win_ready with no new emitting accept in the same cycle, win_valid and win_last go to 0 next cycle.
- Simultaneous: a window consumed and a new emitting pixel accepted in the same cycle gives win_valid=1 next cycle with the new window. Full throughput is one window per clock.
- Edge pixels (row < KH-1 or col < KW-1) update buffers and window registers but produce no output.
- Window count per frame: (IMG_WIDTH-KW+1)*(IMG_HEIGHT-KH+1).
- Data path is pass-through only: no arithmetic, all widths COLOUR_DEPTH.

Decomposition:
- Package conv_pkg:
  - COLOUR_DEPTH and KERNAL_WIDTH/KERNAL_HEIGHT defaults
  - typedef pixel_t (logic [COLOUR_DEPTH-1:0])
  - typedef win_t (pixel_t array of KERNAL_WIDTH*KERNAL_HEIGHT)
  - function win_idx(r,c)
- Sub-module conv_line_buf: one IMG_WIDTH x COLOUR_DEPTH delay memory with write enable and read-before-write at a shared address. Instantiated KERNAL_HEIGHT-1 times.

Test Plan:
- Setup: IMG_WIDTH=5, IMG_HEIGHT=4, 3x3. Frame pixels = r*5+c, pix_sof on pixel 0, win_ready=1.
- Basic frame -> exactly 6 windows. First window = {0,1,2,5,6,7,10,11,12}, valid 1 cycle after pixel 12 accepted. Last window = {7,8,9,12,13,14,17,18,19}, with win_last=1 only on it.
- Back-to-back frames, no gaps, second frame without pix_sof -> 12 windows. Second frame's first window = first frame's first window + 20 per element.
- Backpressure: win_ready=0 for 5 cycles at window 3 -> pix_ready=0 and win_data held unchanged. No window lost or duplicated; order is identical to the basic case.
- Mid-frame resync: pix_sof asserted on the 8th pixel, then a full clean frame -> no window emitted from the aborted frame. The 6 windows match the basic case.
- Reset: reset low for 2 cycles mid-row 2 -> win_valid=0 immediately (asynchronous). A subsequent full frame without pix_sof yields the correct 6 windows.
- Random pix_valid/win_ready toggling over 10 frames -> scoreboard matches the reference window model exactly.
